// File: rtl/ysyx_23060184_rf_wb_arbiter_if.sv
// Signal bundle between decode, EXU, LSU, the register file and the writeback arbiter.
// valid/ready: a transfer happens on a rising edge where both are high; the source holds valid and its payload stable until it sees ready.
interface ysyx_23060184_rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  iss_valid;
    logic                  iss_wen;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic                  iss_ready;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  ex_valid;
    logic [ADDR_WIDTH-1:0] ex_rd;
    logic [DATA_WIDTH-1:0] ex_data;
    logic                  ex_ready;
    logic                  ls_valid;
    logic [ADDR_WIDTH-1:0] ls_rd;
    logic [DATA_WIDTH-1:0] ls_data;
    logic                  ls_ready;
    logic                  rf_wvalid;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  orphan_err;

    modport slave (
        input  iss_valid, iss_wen, iss_rd, rs1, rs2,
        input  ex_valid, ex_rd, ex_data, ls_valid, ls_rd, ls_data,
        output iss_ready, rs1_busy, rs2_busy, ex_ready, ls_ready,
        output rf_wvalid, rf_wen, rf_waddr, rf_wdata, orphan_err
    );

    modport master (
        output iss_valid, iss_wen, iss_rd, rs1, rs2,
        output ex_valid, ex_rd, ex_data, ls_valid, ls_rd, ls_data,
        input  iss_ready, rs1_busy, rs2_busy, ex_ready, ls_ready,
        input  rf_wvalid, rf_wen, rf_waddr, rf_wdata, orphan_err
    );
endinterface

// File: rtl/ysyx_23060184_rf_wb_arbiter.sv
// Register-file writeback arbiter: pending-write scoreboard for issue/hazard checks and
// a round-robin EXU/LSU arbiter feeding a registered register-file write port.
module ysyx_23060184_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    ysyx_23060184_rf_wb_arbiter_if.slave       bus
);
    localparam int NREG = 2 ** ADDR_WIDTH;

    typedef enum logic {
        GRANT_EX = 1'b0,
        GRANT_LS = 1'b1
    } grant_e;

    logic [NREG-1:0]       pending;
    grant_e                last_grant;
    logic                  rf_wvalid_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;
    logic                  orphan_q;

    logic                  waw_stall;
    logic                  iss_ready_c;
    logic                  set_en;
    logic                  grant_ex;
    logic                  grant_ls;
    logic                  wb_fire;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  orphan_hit;
    logic [NREG-1:0]       set_vec;
    logic [NREG-1:0]       clr_vec;

    always_comb begin
        // Stall only on the registered pending bit; a clear landing this cycle is not bypassed.
        waw_stall   = bus.iss_wen && (bus.iss_rd != '0) && pending[bus.iss_rd];
        iss_ready_c = !reset && !waw_stall;
        set_en      = bus.iss_valid && iss_ready_c && bus.iss_wen && (bus.iss_rd != '0);

        if (bus.ex_valid && bus.ls_valid) begin
            grant_ex = (last_grant == GRANT_LS);
        end else begin
            grant_ex = bus.ex_valid;
        end
        grant_ex = grant_ex && !reset;
        grant_ls = bus.ls_valid && !grant_ex && !reset;
        wb_fire  = grant_ex || grant_ls;
        wb_rd    = grant_ex ? bus.ex_rd : bus.ls_rd;
        wb_data  = grant_ex ? bus.ex_data : bus.ls_data;

        // A write to a register being issued in the same cycle is legitimate, not orphaned.
        orphan_hit = wb_fire && (wb_rd != '0) && !pending[wb_rd]
                     && !(set_en && (bus.iss_rd == wb_rd));

        set_vec = '0;
        if (set_en) begin
            set_vec[bus.iss_rd] = 1'b1;
        end
        clr_vec = '0;
        if (rf_wvalid_q && (rf_waddr_q != '0)) begin
            clr_vec[rf_waddr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            last_grant  <= GRANT_LS;
            rf_wvalid_q <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            orphan_q    <= 1'b0;
        end else begin
            // Set is applied after clear so a same-edge issue keeps the bit.
            pending <= (pending & ~clr_vec) | set_vec;
            if (grant_ex) begin
                last_grant <= GRANT_EX;
            end else if (grant_ls) begin
                last_grant <= GRANT_LS;
            end
            rf_wvalid_q <= wb_fire;
            if (wb_fire) begin
                rf_waddr_q <= wb_rd;
                rf_wdata_q <= wb_data;
            end
            if (orphan_hit) begin
                orphan_q <= 1'b1;
            end
        end
    end

    assign bus.iss_ready  = iss_ready_c;
    assign bus.rs1_busy   = !reset && pending[bus.rs1];
    assign bus.rs2_busy   = !reset && pending[bus.rs2];
    assign bus.ex_ready   = grant_ex;
    assign bus.ls_ready   = grant_ls;
    assign bus.rf_wvalid  = rf_wvalid_q;
    assign bus.rf_wen     = rf_wvalid_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.orphan_err = orphan_q;
endmodule

// File: tb/tb_ysyx_23060184_rf_wb_arbiter.sv
// Bench for the writeback arbiter: table of per-cycle stimulus/expectations, a queue of
// expected register-file writes, and a hand-written asynchronous reset sequence.
module tb_ysyx_23060184_rf_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int W  = AW + DW;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [W-1:0] exp_q[$];

    ysyx_23060184_rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_23060184_rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          iv;
        logic          iw;
        logic [AW-1:0] ird;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          ev;
        logic [AW-1:0] erd;
        logic [DW-1:0] ed;
        logic          lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ld;
        logic          x_ir;
        logic          x_b1;
        logic          x_b2;
        logic          x_exr;
        logic          x_lsr;
        logic          x_orph;
    } step_t;

    step_t tbl[$];

    function automatic step_t mk(input int iv, iw, ird, rs1, rs2, ev, erd,
                                 input logic [DW-1:0] ed, input int lv, lrd,
                                 input logic [DW-1:0] ld,
                                 input int ir, b1, b2, exr, lsr, orph);
        step_t s;
        s.iv = 1'(iv);   s.iw = 1'(iw);   s.ird = AW'(ird);
        s.rs1 = AW'(rs1); s.rs2 = AW'(rs2);
        s.ev = 1'(ev);   s.erd = AW'(erd); s.ed = ed;
        s.lv = 1'(lv);   s.lrd = AW'(lrd); s.ld = ld;
        s.x_ir = 1'(ir); s.x_b1 = 1'(b1); s.x_b2 = 1'(b2);
        s.x_exr = 1'(exr); s.x_lsr = 1'(lsr); s.x_orph = 1'(orph);
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.iss_valid = 1'b0; bus.iss_wen = 1'b0; bus.iss_rd = '0;
        bus.rs1 = '0;         bus.rs2 = '0;
        bus.ex_valid = 1'b0;  bus.ex_rd = '0;     bus.ex_data = '0;
        bus.ls_valid = 1'b0;  bus.ls_rd = '0;     bus.ls_data = '0;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic run_step(input step_t s, input int idx);
        logic [W-1:0] w;
        bus.iss_valid = s.iv;  bus.iss_wen = s.iw;  bus.iss_rd = s.ird;
        bus.rs1 = s.rs1;       bus.rs2 = s.rs2;
        bus.ex_valid = s.ev;   bus.ex_rd = s.erd;   bus.ex_data = s.ed;
        bus.ls_valid = s.lv;   bus.ls_rd = s.lrd;   bus.ls_data = s.ld;
        #1;
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check($sformatf("s%0d_rf_wvalid", idx), 32'(bus.rf_wvalid), 32'd1);
            check($sformatf("s%0d_rf_wen", idx), 32'(bus.rf_wen), 32'd1);
            check($sformatf("s%0d_rf_waddr", idx), 32'(bus.rf_waddr), 32'(w[W-1:DW]));
            check($sformatf("s%0d_rf_wdata", idx), bus.rf_wdata, w[DW-1:0]);
        end else begin
            check($sformatf("s%0d_rf_wvalid", idx), 32'(bus.rf_wvalid), 32'd0);
            check($sformatf("s%0d_rf_wen", idx), 32'(bus.rf_wen), 32'd0);
        end
        check($sformatf("s%0d_iss_ready", idx), 32'(bus.iss_ready), 32'(s.x_ir));
        check($sformatf("s%0d_rs1_busy", idx), 32'(bus.rs1_busy), 32'(s.x_b1));
        check($sformatf("s%0d_rs2_busy", idx), 32'(bus.rs2_busy), 32'(s.x_b2));
        check($sformatf("s%0d_ex_ready", idx), 32'(bus.ex_ready), 32'(s.x_exr));
        check($sformatf("s%0d_ls_ready", idx), 32'(bus.ls_ready), 32'(s.x_lsr));
        check($sformatf("s%0d_orphan_err", idx), 32'(bus.orphan_err), 32'(s.x_orph));
        if (s.x_exr) exp_q.push_back({s.erd, s.ed});
        if (s.x_lsr) exp_q.push_back({s.lrd, s.ld});
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive_idle();
        bus.iss_valid = 1'b1;
        bus.ex_valid  = 1'b1; bus.ex_rd = 5'd1;
        bus.ls_valid  = 1'b1; bus.ls_rd = 5'd2;

        // Columns: iv iw ird | rs1 rs2 | ev erd ed | lv lrd ld | ir b1 b2 exr lsr orph
        tbl.push_back(mk(0,0,0, 1,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(1,1,1, 1,2, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(1,1,2, 1,2, 0,0,32'h0,        0,0,32'h0,        1,1,0,0,0,0));
        tbl.push_back(mk(1,1,3, 2,3, 0,0,32'h0,        0,0,32'h0,        1,1,0,0,0,0));
        tbl.push_back(mk(1,1,4, 3,4, 0,0,32'h0,        0,0,32'h0,        1,1,0,0,0,0));
        tbl.push_back(mk(0,0,0, 4,1, 1,1,32'hA0000001, 1,2,32'hB0000002, 1,1,1,1,0,0));
        tbl.push_back(mk(0,0,0, 1,3, 1,3,32'hA0000003, 1,2,32'hB0000002, 1,1,1,0,1,0));
        tbl.push_back(mk(0,0,0, 1,2, 1,3,32'hA0000003, 1,4,32'hB0000004, 1,0,1,1,0,0));
        tbl.push_back(mk(0,0,0, 2,3, 1,0,32'h00005A5A, 1,4,32'hB0000004, 1,0,1,0,1,0));
        tbl.push_back(mk(0,0,0, 3,4, 1,0,32'h00005A5A, 0,0,32'h0,        1,0,1,1,0,0));
        tbl.push_back(mk(0,0,0, 4,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(1,1,5, 5,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 5,5, 1,5,32'hDEADBEEF, 0,0,32'h0,        1,1,1,1,0,0));
        tbl.push_back(mk(0,0,0, 5,0, 0,0,32'h0,        0,0,32'h0,        1,1,0,0,0,0));
        tbl.push_back(mk(0,0,0, 5,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(1,1,7, 7,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(1,1,7, 7,0, 0,0,32'h0,        1,7,32'hC0000007, 0,1,0,0,1,0));
        tbl.push_back(mk(1,1,7, 7,0, 0,0,32'h0,        0,0,32'h0,        0,1,0,0,0,0));
        tbl.push_back(mk(1,1,7, 7,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(1,0,7, 7,0, 1,7,32'hC0000008, 0,0,32'h0,        1,1,0,1,0,0));
        tbl.push_back(mk(0,0,0, 7,0, 0,0,32'h0,        0,0,32'h0,        1,1,0,0,0,0));
        tbl.push_back(mk(1,1,0, 7,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 0,9, 0,0,32'h0,        1,9,32'h00000099, 1,0,0,0,1,0));
        tbl.push_back(mk(0,0,0, 9,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0, 9,0, 1,0,32'h000000FF, 0,0,32'h0,        1,0,0,1,0,1));
        tbl.push_back(mk(0,0,0, 3,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0, 3,0, 1,3,32'h00003333, 0,0,32'h0,        1,0,0,1,0,1));
        tbl.push_back(mk(1,1,3, 3,0, 0,0,32'h0,        0,0,32'h0,        1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0, 3,0, 0,0,32'h0,        0,0,32'h0,        1,1,0,0,0,1));
        tbl.push_back(mk(0,0,0, 3,9, 0,0,32'h0,        0,0,32'h0,        1,1,0,0,0,1));

        // Outputs while reset is held, with requests present.
        @(posedge clk);
        #1;
        check("rst_iss_ready", 32'(bus.iss_ready), 32'd0);
        check("rst_ex_ready", 32'(bus.ex_ready), 32'd0);
        check("rst_ls_ready", 32'(bus.ls_ready), 32'd0);
        check("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        check("rst_rf_wvalid", 32'(bus.rf_wvalid), 32'd0);
        check("rst_rf_wen", 32'(bus.rf_wen), 32'd0);
        check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst_rf_wdata", bus.rf_wdata, 32'd0);
        check("rst_orphan_err", 32'(bus.orphan_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();

        for (int i = 0; i < tbl.size(); i++) begin
            run_step(tbl[i], i);
        end
        check("tbl_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while a write strobe is showing.
        drive_idle();
        bus.rs1 = 5'd3;
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd3; bus.ex_data = 32'h12345678;
        #1;
        check("ar_ex_ready", 32'(bus.ex_ready), 32'd1);
        @(posedge clk);
        #1;
        check("ar_rf_wvalid_pre", 32'(bus.rf_wvalid), 32'd1);
        check("ar_rf_wdata_pre", bus.rf_wdata, 32'h12345678);
        bus.ex_rd = 5'd0; bus.ex_data = 32'h0;
        bus.iss_valid = 1'b1; bus.iss_wen = 1'b1; bus.iss_rd = 5'd6;
        #1;
        reset = 1'b1;
        #1;
        check("ar_rf_wvalid", 32'(bus.rf_wvalid), 32'd0);
        check("ar_rf_wen", 32'(bus.rf_wen), 32'd0);
        check("ar_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check("ar_rf_wdata", bus.rf_wdata, 32'd0);
        check("ar_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        check("ar_orphan_err", 32'(bus.orphan_err), 32'd0);
        check("ar_iss_ready", 32'(bus.iss_ready), 32'd0);
        check("ar_ex_ready", 32'(bus.ex_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ar_rf_wvalid_hold", 32'(bus.rf_wvalid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        bus.rs1 = 5'd3;
        bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_data = 32'h00000001;
        bus.ls_valid = 1'b1; bus.ls_rd = 5'd0; bus.ls_data = 32'h00000002;
        #1;
        check("post_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        check("post_tie_ex_ready", 32'(bus.ex_ready), 32'd1);
        check("post_tie_ls_ready", 32'(bus.ls_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_rf_wvalid", 32'(bus.rf_wvalid), 32'd1);
        check("post_rf_wdata_ex", bus.rf_wdata, 32'h00000001);
        bus.ex_valid = 1'b0;
        @(negedge clk);
        #1;
        check("post_ls_ready", 32'(bus.ls_ready), 32'd1);
        @(posedge clk);
        #1;
        check("post_rf_wdata_ls", bus.rf_wdata, 32'h00000002);
        check("post_orphan_err", 32'(bus.orphan_err), 32'd0);
        drive_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
